// File: rtl/enc_pkg.sv
// Shared widths and state type for the 4-to-2 sequential encoder.
// ENC_ROUND_ROBIN_EN (optional) switches arbitration from fixed priority to round robin.
package enc_pkg;
    localparam int REQ_W = 4;
    localparam int IDX_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;
endpackage

// File: rtl/enc_pick4.sv
// Combinational picker: first set bit of vec searching upward from start, wrapping mod 4.
// onehot_left flags that vec holds exactly one set bit.
module enc_pick4
    import enc_pkg::*;
(
    input  logic [REQ_W-1:0] vec,
    input  logic [IDX_W-1:0] start,
    output logic [IDX_W-1:0] idx,
    output logic             found,
    output logic             onehot_left
);

    logic [IDX_W-1:0] cand;

    // Walk offsets from far to near so the nearest hit to start wins.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = REQ_W - 1; i >= 0; i--) begin
            cand = start + IDX_W'(i);
            if (vec[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
    end

    assign onehot_left = (vec != '0) && ((vec & (vec - REQ_W'(1))) == '0);

endmodule

// File: rtl/encoder_4to2_seq.sv
// Accepts a multi-hot request word and drains it one index per output beat.
// Define ENC_ROUND_ROBIN_EN for a persistent round-robin pointer; default is lowest-index-first.
//
// state | meaning
// IDLE  | waiting for a request word, in_ready follows en
// DRAIN | emitting the pending bits, out_valid follows en
module encoder_4to2_seq
    import enc_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [REQ_W-1:0] req,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] idx,
    output logic             last,
    output logic             busy
);

    state_t           state, state_nxt;
    logic [REQ_W-1:0] pending, pending_nxt;
    logic [IDX_W-1:0] start;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_found;
    logic             pick_one;
    logic             out_fire;

`ifdef ENC_ROUND_ROBIN_EN
    logic [IDX_W-1:0] ptr, ptr_nxt;
    assign start = ptr;
`else
    assign start = '0;
`endif

    enc_pick4 u_pick (
        .vec         (pending),
        .start       (start),
        .idx         (pick_idx),
        .found       (pick_found),
        .onehot_left (pick_one)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            pending <= '0;
`ifdef ENC_ROUND_ROBIN_EN
            ptr     <= '0;
`endif
        end else begin
            state   <= state_nxt;
            pending <= pending_nxt;
`ifdef ENC_ROUND_ROBIN_EN
            ptr     <= ptr_nxt;
`endif
        end
    end

    assign out_fire = out_valid && out_ready && pick_found;

    always_comb begin
        state_nxt   = state;
        pending_nxt = pending;
`ifdef ENC_ROUND_ROBIN_EN
        ptr_nxt     = ptr;
`endif
        case (state)
            IDLE: begin
                // An all-zero word is accepted but never enters DRAIN.
                if (en && in_valid && (req != '0)) begin
                    pending_nxt = req;
                    state_nxt   = DRAIN;
                end
            end
            DRAIN: begin
                if (out_fire) begin
                    pending_nxt = pending & ~(REQ_W'(1) << pick_idx);
`ifdef ENC_ROUND_ROBIN_EN
                    ptr_nxt     = pick_idx + IDX_W'(1);
`endif
                    if (pick_one) begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy      = (state == DRAIN);
    assign in_ready  = en && (state == IDLE);
    assign out_valid = en && (state == DRAIN);
    assign idx       = busy ? pick_idx : '0;
    assign last      = busy && pick_one;

endmodule
